spart_driver_fifo: RTL and testbench

- Processor-side driver for the SPART serial port.
- Programs the baud divisor after reset, or whenever br_cfg changes.
- Reads received bytes into an internal RX FIFO, optionally transforms them, and writes them back for transmission.
- Successor to the single-byte echo driver: adds a parametrised clock/baud divisor table, a DEPTH-entry buffer, an echo/uppercase mode, runtime reconfiguration, and status outputs.

---
 rtl/spart_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/spart_driver_fifo.sv | 153 +++++++++++++++
 tb/tb_spart_driver_fifo.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared constants, FSM state type and baud-divisor helper for the SPART driver.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_GAP1,
    CFG_HI,
    IDLE,
    RD,
    WR,
    GAP
  } state_e;

  // Rounded divisor for a 16x-oversampling receiver: round(clk / (16 * rate)).
  function automatic logic [15:0] div_for(input int unsigned clk_hz,
                                          input int unsigned base,
                                          input logic [1:0]  cfg);
    int unsigned rate;
    int unsigned d;
    rate = base << cfg;
    d    = ((clk_hz / (8 * rate)) + 1) / 2;
    return d[15:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word and wrap-around pointers.
module sync_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = head_q;

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_ONE;
    end
    // Head tracks the oldest entry; it bypasses storage when the queue is (becoming) empty.
    head_d = head_q;
    if (do_pop && count_q > CNT_ONE) begin
      head_d = mem_q[rd_ptr_q + PTR_ONE];
    end else if (do_push && (empty || do_pop)) begin
      head_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/spart_driver_fifo.sv
// SPART driver: programs the baud divisor, buffers received bytes and echoes
// them (optionally upper-cased) back through the transmit register.
import spart_pkg::*;

module spart_driver_fifo #(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned BASE_BAUD = 4800,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             br_cfg,
  input  logic                   mode,
  input  logic                   rda,
  input  logic                   tbr,
  output logic                   iocs,
  output logic                   iorw,
  output logic [1:0]             ioaddr,
  inout  wire logic [DATA_W-1:0] databus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   cfg_busy,
  output logic                   rx_stall
);

  localparam logic [3:0][15:0] DIV_TAB = {
    div_for(CLK_HZ, BASE_BAUD, 2'd3),
    div_for(CLK_HZ, BASE_BAUD, 2'd2),
    div_for(CLK_HZ, BASE_BAUD, 2'd1),
    div_for(CLK_HZ, BASE_BAUD, 2'd0)
  };

  state_e            state_q, state_d, arb_state;
  logic [1:0]        cfg_q, cfg_d, arb_cfg;
  logic              run_q;
  logic [15:0]       div;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_din, fifo_dout, bus_out;
  logic              bus_oe;
  logic [7:0]        rx_lo;

  assign div       = DIV_TAB[cfg_q];
  assign fifo_push = (state_q == RD);
  assign fifo_pop  = (state_q == WR);
  assign rx_stall  = rda & fifo_full;
  assign databus   = bus_oe ? bus_out : 'z;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rx_lo    = databus[7:0];
    fifo_din = databus;
    if (mode && rx_lo >= 8'h61 && rx_lo <= 8'h7A) begin
      fifo_din[7:0] = rx_lo - 8'h20;
    end
  end

  always_comb begin
    arb_state = IDLE;
    arb_cfg   = cfg_q;
    if (br_cfg != cfg_q) begin
      arb_state = CFG_LO;
      arb_cfg   = br_cfg;
    end else if (rda && !fifo_full) begin
      arb_state = RD;
    end else if (tbr && !fifo_empty) begin
      arb_state = WR;
    end
  end

  // GAP arbitrates as IDLE would, so the mandatory idle cycle doubles as the
  // decision cycle and a read is followed by its echo two cycles later.
  // run_q holds the FSM in a quiet CFG_LO for the first cycle after reset.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    if (run_q) begin
      unique case (state_q)
        CFG_LO:        state_d = CFG_GAP1;
        CFG_GAP1:      state_d = CFG_HI;
        CFG_HI, RD, WR: state_d = GAP;
        IDLE, GAP: begin
          state_d = arb_state;
          cfg_d   = arb_cfg;
        end
        default:       state_d = CFG_LO;
      endcase
    end
  end

  always_comb begin
    iocs     = 1'b0;
    iorw     = 1'b1;
    ioaddr   = ADDR_DATA;
    bus_oe   = 1'b0;
    bus_out  = '0;
    cfg_busy = !run_q || (state_q inside {CFG_LO, CFG_GAP1, CFG_HI});
    if (run_q) begin
      unique case (state_q)
        CFG_LO: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          ioaddr  = ADDR_DBL;
          bus_oe  = 1'b1;
          bus_out = DATA_W'(div[7:0]);
        end
        CFG_HI: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          ioaddr  = ADDR_DBH;
          bus_oe  = 1'b1;
          bus_out = DATA_W'(div[15:8]);
        end
        RD: begin
          iocs = 1'b1;
        end
        WR: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          bus_oe  = 1'b1;
          bus_out = fifo_dout;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CFG_LO;
      cfg_q   <= br_cfg;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spart_driver_fifo.sv
// Scoreboard bench for spart_driver_fifo: a SPART model feeds random bytes,
// expected echoes and divisor writes are queued at issue time and checked on output.
module tb_spart_driver_fifo;
  import spart_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       mode = 1'b0;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [3:0] fifo_count;
  logic       cfg_busy, rx_stall;

  logic [7:0] bus_drv = 8'h00;
  assign databus = (iocs && iorw) ? bus_drv : 8'hzz;

  spart_driver_fifo #(
    .CLK_HZ    (100000000),
    .BASE_BAUD (4800),
    .DEPTH     (DEPTH),
    .DATA_W    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .br_cfg     (br_cfg),
    .mode       (mode),
    .rda        (rda),
    .tbr        (tbr),
    .iocs       (iocs),
    .iorw       (iorw),
    .ioaddr     (ioaddr),
    .databus    (databus),
    .fifo_count (fifo_count),
    .cfg_busy   (cfg_busy),
    .rx_stall   (rx_stall)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned reads = 0;
  int unsigned model_cnt = 0;
  int unsigned last_rd_cyc = 0;
  int unsigned last_lo_cyc = 0;
  bit          rd_pend = 0, wr_pend = 0, prev_iocs = 0;
  bit          check_lat = 0, check_cfg_after_rd = 0;

  logic [7:0]  src_q[$];
  logic [7:0]  data_exp_q[$];
  logic [9:0]  cfg_exp_q[$];
  logic [15:0] div_exp[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] upcase(input logic [7:0] b, input logic m);
    if (m && b >= "a" && b <= "z") return b - 8'd32;
    return b;
  endfunction

  task automatic send(input logic [7:0] b);
    src_q.push_back(b);
    data_exp_q.push_back(upcase(b, mode));
  endtask

  task automatic expect_cfg(input logic [1:0] c);
    logic [15:0] d;
    d = div_exp[c];
    cfg_exp_q.push_back({ADDR_DBL, d[7:0]});
    cfg_exp_q.push_back({ADDR_DBH, d[15:8]});
  endtask

  function automatic logic [7:0] rand_byte();
    if ($urandom_range(0, 1) == 1) return 8'($urandom_range(8'h58, 8'h7F));
    return 8'($urandom);
  endfunction

  task automatic drain(input int unsigned budget, input bit rnd_tbr);
    int unsigned n = 0;
    while ((data_exp_q.size() != 0 || cfg_exp_q.size() != 0 || src_q.size() != 0) && n < budget) begin
      @(posedge clk);
      if (rnd_tbr) tbr = 1'($urandom_range(0, 1));
      n++;
    end
    chk("drain_timeout", n < budget, 1);
    repeat (3) @(posedge clk);
  endtask

  // SPART model and output monitor
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst) begin
      model_cnt = 0;
      rd_pend   = 0;
      wr_pend   = 0;
    end else begin
      if (rd_pend) begin
        model_cnt++;
        reads++;
        void'(src_q.pop_front());
        rd_pend = 0;
      end
      if (wr_pend) begin
        model_cnt--;
        wr_pend = 0;
      end
    end
    chk("fifo_count", fifo_count, model_cnt);
    chk("rx_stall", rx_stall, (rda && model_cnt == DEPTH));
    if (iocs) begin
      chk("iocs_gap", prev_iocs, 0);
      if (iorw) begin
        chk("rd_addr", ioaddr, ADDR_DATA);
        chk("rd_with_rda", rda, 1);
        chk("rd_busy", cfg_busy, 0);
        last_rd_cyc = cyc;
        rd_pend = 1;
      end else if (ioaddr == ADDR_DATA) begin
        chk("wr_busy", cfg_busy, 0);
        if (data_exp_q.size() == 0) begin
          chk("wr_unexpected", databus, 8'hxx);
        end else begin
          chk("wr_data", databus, data_exp_q.pop_front());
        end
        if (check_lat) chk("rd_to_wr_latency", cyc - last_rd_cyc, 2);
        wr_pend = 1;
      end else begin
        chk("cfg_busy_hi", cfg_busy, 1);
        if (cfg_exp_q.size() == 0) begin
          chk("cfg_unexpected", {ioaddr, databus}, 10'h3ff);
        end else begin
          e = cfg_exp_q.pop_front();
          chk("cfg_write", {ioaddr, databus}, e);
        end
        if (ioaddr == ADDR_DBL) begin
          if (check_cfg_after_rd) chk("cfg_after_rd_gap", cyc - last_rd_cyc, 2);
          last_lo_cyc = cyc;
        end else begin
          chk("cfg_lo_hi_gap", cyc - last_lo_cyc, 2);
        end
      end
    end
    prev_iocs = iocs;
    rda     = (src_q.size() != 0);
    bus_drv = (src_q.size() != 0) ? src_q[0] : 8'h00;
  end

  initial begin
    int unsigned n;
    int unsigned r0;
    div_exp[0] = 16'h0516;
    div_exp[1] = 16'h028B;
    div_exp[2] = 16'h0146;
    div_exp[3] = 16'h00A3;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iocs", iocs, 0);
    chk("rst_iorw", iorw, 1);
    chk("rst_ioaddr", ioaddr, 0);
    chk("rst_bus_z", databus === 8'hzz, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_cfg_busy", cfg_busy, 1);
    chk("rst_rx_stall", rx_stall, 0);
    expect_cfg(2'b01);
    rst = 1'b1;
    drain(100, 0);
    chk("cfg_busy_done", cfg_busy, 0);

    // Plain echo with latency check
    mode = 1'b0;
    tbr  = 1'b1;
    check_lat = 1;
    send(8'h41);
    drain(100, 0);
    check_lat = 0;

    // Uppercase boundaries
    mode = 1'b1;
    send(8'h61); send(8'h7A); send(8'h7B); send(8'h40);
    send(8'h60);
    drain(200, 0);

    // Randomized batches with random tbr
    for (int k = 0; k < 6; k++) begin
      mode = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 12);
      for (int unsigned i = 0; i < n; i++) send(rand_byte());
      drain(600, 1);
    end

    // Full FIFO stall
    tbr = 1'b0;
    mode = 1'b1;
    r0 = reads;
    for (int i = 0; i < 10; i++) send(rand_byte());
    repeat (60) @(posedge clk);
    #1;
    chk("stall_count", fifo_count, DEPTH);
    chk("stall_flag", rx_stall, 1);
    chk("stall_reads", reads - r0, 8);
    tbr = 1'b1;
    drain(400, 0);
    chk("stall_total_reads", reads - r0, 10);

    // br_cfg change while a read is in flight
    tbr = 1'b0;
    send(8'h62);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(iocs && iorw) && n < 50);
    chk("cfgchg_rd_seen", iocs && iorw, 1);
    check_cfg_after_rd = 1;
    br_cfg = 2'b11;
    expect_cfg(2'b11);
    n = 0;
    while (cfg_exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("cfgchg_timeout", n < 50, 1);
    check_cfg_after_rd = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("cfgchg_fifo_kept", fifo_count, 1);
    chk("cfgchg_busy", cfg_busy, 0);
    tbr = 1'b1;
    drain(100, 0);

    // Reset in the middle of a write
    tbr = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_byte());
    n = 0;
    while (fifo_count != 3 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("rstwr_fill", fifo_count, 3);
    tbr = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(iocs && !iorw && ioaddr == ADDR_DATA) && n < 50);
    chk("rstwr_wr_seen", iocs && !iorw, 1);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rstwr_iocs", iocs, 0);
    chk("rstwr_bus_z", databus === 8'hzz, 1);
    chk("rstwr_count", fifo_count, 0);
    chk("rstwr_busy", cfg_busy, 1);
    data_exp_q.delete();
    expect_cfg(2'b11);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drain(100, 0);

    // Traffic after reset
    mode = 1'($urandom_range(0, 1));
    for (int i = 0; i < 5; i++) send(rand_byte());
    drain(300, 1);
    chk("queues_empty", data_exp_q.size() + cfg_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
